frog_hop_controller: RTL and testbench

- Upstream of the game-state FSM: turns keyboard keycodes into grid hops for the three frogs, one frog active at a time.
- Parks each frog that reaches a free home slot, then spawns the next frog.
- Publishes Frog1..3 X/Y positions and a one-frame dead_frog pulse that the game-state FSM consumes.
- Runs entirely on frame_clk; one update per video frame.

---
 rtl/frogger_pkg.sv | 64 ++++++
 rtl/frog_move_calc.sv | 77 +++++++
 rtl/frog_hop_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_frog_hop_controller.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared constants, types and key-decode helpers for the frog hop controller.
// Holds the playfield geometry, the USB keycodes for W/A/S/D, the home-slot
// X positions, the controller state enum and the hop direction enum.
package frogger_pkg;

    // USB HID keycodes for the four direction keys
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    // Left-edge X of the three home slots on the home row
    localparam logic [10:0] HOME_X0 = 11'd120;
    localparam logic [10:0] HOME_X1 = 11'd280;
    localparam logic [10:0] HOME_X2 = 11'd480;

    // Playfield geometry in pixels
    localparam logic [10:0] CELL      = 11'd40;
    localparam logic [10:0] START_X   = 11'd320;
    localparam logic [10:0] START_Y   = 11'd440;
    localparam logic [10:0] HOME_Y    = 11'd40;
    localparam logic [10:0] X_MAX     = 11'd600;
    localparam logic [10:0] RIVER_TOP = 11'd80;
    localparam logic [10:0] RIVER_BOT = 11'd200;

    // Frame timers
    localparam logic [3:0] HOP_FRAMES   = 4'd8;
    localparam logic [4:0] DEATH_FRAMES = 5'd30;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HOMED = 2'd1,
        DYING = 2'd2,
        DONE  = 2'd3
    } frog_state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } hop_dir_e;

    // True when the keycode is one of the four direction keys
    function automatic logic is_dir_key(input logic [7:0] k);
        logic r;
        r = (k == KEY_W) || (k == KEY_S) || (k == KEY_A) || (k == KEY_D);
        return r;
    endfunction

    // Direction of a keycode; only meaningful when is_dir_key() is true
    function automatic hop_dir_e key_to_dir(input logic [7:0] k);
        hop_dir_e d;
        case (k)
            KEY_W:   d = DIR_UP;
            KEY_S:   d = DIR_DOWN;
            KEY_A:   d = DIR_LEFT;
            KEY_D:   d = DIR_RIGHT;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/frog_move_calc.sv
// Combinational next-position logic for the active frog.
// Ports:
//   cur_x, cur_y   : current position of the active frog
//   hop_dir        : direction of the requested hop
//   log_dx         : signed px/frame log drift (4-bit two's complement)
//   slot_used      : home slots already occupied (bit0 = X 120)
//   hop_x, hop_y   : position after a clamped hop in hop_dir
//   drift_x        : X after applying log drift (valid when !drift_oob)
//   in_river       : current Y lies in the river rows
//   drift_oob      : drifted X would leave [0, X_MAX]
//   at_home        : hop lands on the home row
//   home_bit       : one-hot home slot matched by hop_x (zero if none)
//   home_free      : hop_x matches a slot that is still free
module frog_move_calc
    import frogger_pkg::*;
(
    input  logic [10:0] cur_x,
    input  logic [10:0] cur_y,
    input  hop_dir_e    hop_dir,
    input  logic [3:0]  log_dx,
    input  logic [2:0]  slot_used,
    output logic [10:0] hop_x,
    output logic [10:0] hop_y,
    output logic [10:0] drift_x,
    output logic        in_river,
    output logic        drift_oob,
    output logic        at_home,
    output logic [2:0]  home_bit,
    output logic        home_free
);

    logic signed [11:0] drift_sum_s;

    // Clamped hop target for each direction
    always_comb begin
        hop_x = cur_x;
        hop_y = cur_y;
        case (hop_dir)
            DIR_UP: begin
                if (cur_y >= HOME_Y + CELL) hop_y = cur_y - CELL;
                else                        hop_y = HOME_Y;
            end
            DIR_DOWN: begin
                if (cur_y + CELL > START_Y) hop_y = START_Y;
                else                        hop_y = cur_y + CELL;
            end
            DIR_LEFT: begin
                if (cur_x >= CELL) hop_x = cur_x - CELL;
                else               hop_x = 11'd0;
            end
            DIR_RIGHT: begin
                if (cur_x + CELL > X_MAX) hop_x = X_MAX;
                else                      hop_x = cur_x + CELL;
            end
            default: begin
                hop_x = cur_x;
                hop_y = cur_y;
            end
        endcase
    end

    // Log drift in 12-bit signed so an underflow shows up as a negative sum
    always_comb begin
        drift_sum_s = $signed({1'b0, cur_x}) + $signed({{8{log_dx[3]}}, log_dx});
        drift_oob   = (drift_sum_s < 12'sd0) || (drift_sum_s > $signed({1'b0, X_MAX}));
        drift_x     = drift_sum_s[10:0];
        in_river    = (cur_y >= RIVER_TOP) && (cur_y <= RIVER_BOT);
    end

    // Home-row landing decode
    always_comb begin
        at_home   = (hop_y == HOME_Y);
        home_bit  = {(hop_x == HOME_X2), (hop_x == HOME_X1), (hop_x == HOME_X0)};
        home_free = |(home_bit & ~slot_used);
    end

endmodule

// File: rtl/frog_hop_controller.sv
// Frog hop controller: turns direction-key edges into grid hops for three
// frogs (one active at a time), applies log drift in the river, parks frogs
// in free home slots, and runs the death/respawn timer.
// Ports:
//   frame_clk       : frame-rate clock, one update per video frame
//   game_restart_n  : asynchronous active-low reset
//   keycode         : USB keycode (W/S/A/D hop, anything else is no key)
//   hazard          : active frog overlaps a car or open water this frame
//   log_dx          : signed drift of the log under the frog (river rows only)
//   game_over       : freezes the whole block while high
//   FrogN_X/Y       : registered frog positions, (0,0) = parked off-field
//   dead_frog       : one-frame pulse when the active frog dies
//   active_frog     : active frog index 0..2, 3 once all frogs are home
module frog_hop_controller
    import frogger_pkg::*;
(
    input  logic        frame_clk,
    input  logic        game_restart_n,
    input  logic [7:0]  keycode,
    input  logic        hazard,
    input  logic [3:0]  log_dx,
    input  logic        game_over,
    output logic [10:0] Frog1_X,
    output logic [10:0] Frog1_Y,
    output logic [10:0] Frog2_X,
    output logic [10:0] Frog2_Y,
    output logic [10:0] Frog3_X,
    output logic [10:0] Frog3_Y,
    output logic        dead_frog,
    output logic [1:0]  active_frog
);

    frog_state_e state_r,  state_nx_s;
    logic [4:0]  death_cnt_r, death_cnt_nx_s;
    logic [3:0]  cooldown_r, cooldown_nx_s;
    logic [2:0]  slot_used_r, slot_used_nx_s;
    logic [7:0]  key_prev_r, key_prev_nx_s;
    logic [1:0]  active_r, active_nx_s;
    logic        dead_r, dead_nx_s;
    logic [10:0] frog_x_r [3];
    logic [10:0] frog_y_r [3];
    logic [10:0] frog_x_nx_s [3];
    logic [10:0] frog_y_nx_s [3];

    logic [10:0] cur_x_s, cur_y_s;
    logic [10:0] hop_x_s, hop_y_s, drift_x_s;
    logic        in_river_s, drift_oob_s, at_home_s, home_free_s;
    logic [2:0]  home_bit_s;
    logic        hop_req_s, hop_acc_s, die_s, pos_wr_s;
    logic [1:0]  wr_idx_s;
    logic [10:0] pos_x_s, pos_y_s;

    // Position of the currently active frog
    always_comb begin
        case (active_r)
            2'd0: begin cur_x_s = frog_x_r[0]; cur_y_s = frog_y_r[0]; end
            2'd1: begin cur_x_s = frog_x_r[1]; cur_y_s = frog_y_r[1]; end
            2'd2: begin cur_x_s = frog_x_r[2]; cur_y_s = frog_y_r[2]; end
            default: begin cur_x_s = 11'd0; cur_y_s = 11'd0; end
        endcase
    end

    // A new direction keycode (different from last frame's) asks for one hop
    always_comb begin
        hop_req_s = (keycode != key_prev_r) && is_dir_key(keycode);
        hop_acc_s = hop_req_s && (cooldown_r == 4'd0);
    end

    frog_move_calc u_move (
        .cur_x     (cur_x_s),
        .cur_y     (cur_y_s),
        .hop_dir   (key_to_dir(keycode)),
        .log_dx    (log_dx),
        .slot_used (slot_used_r),
        .hop_x     (hop_x_s),
        .hop_y     (hop_y_s),
        .drift_x   (drift_x_s),
        .in_river  (in_river_s),
        .drift_oob (drift_oob_s),
        .at_home   (at_home_s),
        .home_bit  (home_bit_s),
        .home_free (home_free_s)
    );

    // Next-state and next-output logic; game_over freezes every state.
    // On any death the frog keeps its pre-death position.
    always_comb begin
        state_nx_s     = state_r;
        death_cnt_nx_s = death_cnt_r;
        cooldown_nx_s  = cooldown_r;
        slot_used_nx_s = slot_used_r;
        key_prev_nx_s  = game_over ? key_prev_r : keycode;
        active_nx_s    = active_r;
        dead_nx_s      = 1'b0;
        die_s          = 1'b0;
        pos_wr_s       = 1'b0;
        wr_idx_s       = active_r;
        pos_x_s        = cur_x_s;
        pos_y_s        = cur_y_s;

        case (state_r)
            ALIVE: begin
                if (game_over) begin
                    state_nx_s = ALIVE;
                end else if (hazard) begin
                    die_s = 1'b1;
                end else if (hop_acc_s) begin
                    cooldown_nx_s = HOP_FRAMES;
                    if (at_home_s) begin
                        if (home_free_s) begin
                            pos_wr_s       = 1'b1;
                            pos_x_s        = hop_x_s;
                            pos_y_s        = hop_y_s;
                            slot_used_nx_s = slot_used_r | home_bit_s;
                            state_nx_s     = HOMED;
                        end else begin
                            die_s = 1'b1;
                        end
                    end else begin
                        pos_wr_s = 1'b1;
                        pos_x_s  = hop_x_s;
                        pos_y_s  = hop_y_s;
                    end
                end else begin
                    if (cooldown_r != 4'd0) cooldown_nx_s = cooldown_r - 4'd1;
                    else                    cooldown_nx_s = 4'd0;
                    if (in_river_s) begin
                        if (drift_oob_s) begin
                            die_s = 1'b1;
                        end else begin
                            pos_wr_s = 1'b1;
                            pos_x_s  = drift_x_s;
                        end
                    end else begin
                        pos_wr_s = 1'b0;
                    end
                end
            end
            HOMED: begin
                if (game_over) begin
                    state_nx_s = HOMED;
                end else if (active_r == 2'd2) begin
                    active_nx_s = 2'd3;
                    state_nx_s  = DONE;
                end else begin
                    active_nx_s   = active_r + 2'd1;
                    wr_idx_s      = active_r + 2'd1;
                    pos_wr_s      = 1'b1;
                    pos_x_s       = START_X;
                    pos_y_s       = START_Y;
                    cooldown_nx_s = 4'd0;
                    state_nx_s    = ALIVE;
                end
            end
            DYING: begin
                if (game_over) begin
                    state_nx_s = DYING;
                end else if (death_cnt_r == 5'd0) begin
                    pos_wr_s      = 1'b1;
                    pos_x_s       = START_X;
                    pos_y_s       = START_Y;
                    cooldown_nx_s = 4'd0;
                    state_nx_s    = ALIVE;
                end else begin
                    death_cnt_nx_s = death_cnt_r - 5'd1;
                end
            end
            DONE: begin
                state_nx_s = DONE;
            end
            default: begin
                state_nx_s = state_r;
            end
        endcase

        if (die_s) begin
            state_nx_s     = DYING;
            death_cnt_nx_s = DEATH_FRAMES - 5'd1;
            dead_nx_s      = 1'b1;
        end else begin
            dead_nx_s = 1'b0;
        end

        for (int i = 0; i < 3; i++) begin
            if (pos_wr_s && (wr_idx_s == 2'(i))) begin
                frog_x_nx_s[i] = pos_x_s;
                frog_y_nx_s[i] = pos_y_s;
            end else begin
                frog_x_nx_s[i] = frog_x_r[i];
                frog_y_nx_s[i] = frog_y_r[i];
            end
        end
    end

    // State and output registers
    always_ff @(posedge frame_clk or negedge game_restart_n) begin
        if (!game_restart_n) begin
            state_r     <= ALIVE;
            death_cnt_r <= 5'd0;
            cooldown_r  <= 4'd0;
            slot_used_r <= 3'd0;
            key_prev_r  <= 8'd0;
            active_r    <= 2'd0;
            dead_r      <= 1'b0;
            frog_x_r[0] <= START_X;
            frog_y_r[0] <= START_Y;
            frog_x_r[1] <= 11'd0;
            frog_y_r[1] <= 11'd0;
            frog_x_r[2] <= 11'd0;
            frog_y_r[2] <= 11'd0;
        end else begin
            state_r     <= state_nx_s;
            death_cnt_r <= death_cnt_nx_s;
            cooldown_r  <= cooldown_nx_s;
            slot_used_r <= slot_used_nx_s;
            key_prev_r  <= key_prev_nx_s;
            active_r    <= active_nx_s;
            dead_r      <= dead_nx_s;
            for (int i = 0; i < 3; i++) begin
                frog_x_r[i] <= frog_x_nx_s[i];
                frog_y_r[i] <= frog_y_nx_s[i];
            end
        end
    end

    assign Frog1_X     = frog_x_r[0];
    assign Frog1_Y     = frog_y_r[0];
    assign Frog2_X     = frog_x_r[1];
    assign Frog2_Y     = frog_y_r[1];
    assign Frog3_X     = frog_x_r[2];
    assign Frog3_Y     = frog_y_r[2];
    assign dead_frog   = dead_r;
    assign active_frog = active_r;

endmodule

// File: tb/tb_frog_hop_controller.sv
// Self-checking bench for frog_hop_controller: a table of directed frames,
// hand-written multi-frame sequences, and randomized frames, all compared
// against a frame-level behavioural model of the game rules.
module tb_frog_hop_controller;

    localparam int KW = 'h1A;
    localparam int KS = 'h16;
    localparam int KA = 'h04;
    localparam int KD = 'h07;
    localparam int DX_M3 = 13;  // -3 as a 4-bit two's complement value

    logic        frame_clk = 1'b0;
    logic        game_restart_n;
    logic [7:0]  keycode;
    logic        hazard;
    logic [3:0]  log_dx;
    logic        game_over;
    logic [10:0] Frog1_X, Frog1_Y, Frog2_X, Frog2_Y, Frog3_X, Frog3_Y;
    logic        dead_frog;
    logic [1:0]  active_frog;

    always #5 frame_clk = ~frame_clk;

    frog_hop_controller dut (
        .frame_clk      (frame_clk),
        .game_restart_n (game_restart_n),
        .keycode        (keycode),
        .hazard         (hazard),
        .log_dx         (log_dx),
        .game_over      (game_over),
        .Frog1_X        (Frog1_X),
        .Frog1_Y        (Frog1_Y),
        .Frog2_X        (Frog2_X),
        .Frog2_Y        (Frog2_Y),
        .Frog3_X        (Frog3_X),
        .Frog3_Y        (Frog3_Y),
        .dead_frog      (dead_frog),
        .active_frog    (active_frog)
    );

    int n_pass = 0;
    int n_total = 0;

    // ---------------- behavioural model ----------------
    int mx[3];
    int my[3];
    int m_act, m_dead, m_cool, m_prev, m_die_left;
    bit m_slot[3];
    bit m_homed, m_done;

    task automatic model_reset();
        mx = '{320, 0, 0};
        my = '{440, 0, 0};
        m_act = 0; m_dead = 0; m_cool = 0; m_prev = 0; m_die_left = 0;
        m_slot = '{0, 0, 0};
        m_homed = 0; m_done = 0;
    endtask

    function automatic bit is_dir(int k);
        return (k == KW) || (k == KS) || (k == KA) || (k == KD);
    endfunction

    task automatic model_kill();
        m_dead = 1;
        m_die_left = 30;
    endtask

    task automatic model_step(int k, bit haz, int dx, bit go);
        int x, y, nx, ny, s, sdx;
        bit hop;
        m_dead = 0;
        if (go) return;
        if (m_done) begin
        end else if (m_homed) begin
            m_homed = 0;
            m_act++;
            if (m_act < 3) begin
                mx[m_act] = 320; my[m_act] = 440; m_cool = 0;
            end else begin
                m_done = 1;
            end
        end else if (m_die_left > 0) begin
            m_die_left--;
            if (m_die_left == 0) begin
                mx[m_act] = 320; my[m_act] = 440; m_cool = 0;
            end
        end else begin
            x = mx[m_act]; y = my[m_act];
            hop = (k != m_prev) && is_dir(k) && (m_cool == 0);
            if (haz) begin
                model_kill();
            end else if (hop) begin
                m_cool = 8;
                nx = x; ny = y;
                if (k == KW) ny = (y - 40 < 40) ? 40 : y - 40;
                if (k == KS) ny = (y + 40 > 440) ? 440 : y + 40;
                if (k == KA) nx = (x - 40 < 0) ? 0 : x - 40;
                if (k == KD) nx = (x + 40 > 600) ? 600 : x + 40;
                if (ny == 40) begin
                    s = (nx == 120) ? 0 : (nx == 280) ? 1 : (nx == 480) ? 2 : -1;
                    if (s >= 0 && !m_slot[s]) begin
                        mx[m_act] = nx; my[m_act] = ny;
                        m_slot[s] = 1; m_homed = 1;
                    end else begin
                        model_kill();
                    end
                end else begin
                    mx[m_act] = nx; my[m_act] = ny;
                end
            end else begin
                if (m_cool > 0) m_cool--;
                if (y >= 80 && y <= 200) begin
                    sdx = (dx > 7) ? dx - 16 : dx;
                    nx = x + sdx;
                    if (nx < 0 || nx > 600) model_kill();
                    else mx[m_act] = nx;
                end
            end
        end
        m_prev = k;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, int got, int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic cmp_model(string tag);
        int gx[3], gy[3];
        bit ok;
        gx = '{int'(Frog1_X), int'(Frog2_X), int'(Frog3_X)};
        gy = '{int'(Frog1_Y), int'(Frog2_Y), int'(Frog3_Y)};
        ok = (int'(active_frog) == m_act) && (int'(dead_frog) == m_dead);
        for (int i = 0; i < 3; i++) ok = ok && (gx[i] == mx[i]) && (gy[i] == my[i]);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL model_%s @%0t: got act=%0d dead=%0d F1=(%0d,%0d) F2=(%0d,%0d) F3=(%0d,%0d), expected act=%0d dead=%0d F1=(%0d,%0d) F2=(%0d,%0d) F3=(%0d,%0d)",
                      tag, $time, active_frog, dead_frog, gx[0], gy[0], gx[1], gy[1], gx[2], gy[2],
                      m_act, m_dead, mx[0], my[0], mx[1], my[1], mx[2], my[2]);
    endtask

    task automatic frame(int k, bit haz, int dx, bit go);
        @(negedge frame_clk);
        keycode = k[7:0]; hazard = haz; log_dx = dx[3:0]; game_over = go;
        @(posedge frame_clk);
        model_step(k, haz, dx, go);
        #1;
        cmp_model("frame");
    endtask

    task automatic hop(int k);
        frame(k, 0, 0, 0);
        repeat (9) frame(0, 0, 0, 0);
    endtask

    // Reset asserted mid-frame; outputs must return to reset values at once
    task automatic do_reset();
        @(negedge frame_clk);
        game_restart_n = 1'b0;
        keycode = 8'd0; hazard = 1'b0; log_dx = 4'd0; game_over = 1'b0;
        #1;
        model_reset();
        cmp_model("reset");
        check("reset_F1_X", int'(Frog1_X), 320);
        check("reset_dead", int'(dead_frog), 0);
        @(negedge frame_clk);
        game_restart_n = 1'b1;
    endtask

    typedef struct {
        int rep; int key; bit haz;
        int exp_x; int exp_y; bit exp_dead; int exp_act;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xe, r, k;
        game_restart_n = 1'b0;
        keycode = 8'd0; hazard = 1'b0; log_dx = 4'd0; game_over = 1'b0;

        // ---- table-driven directed frames (Frog1 only) ----
        tbl.push_back('{1,  KW, 0, 320, 400, 0, 0});
        tbl.push_back('{19, KW, 0, 320, 400, 0, 0});
        tbl.push_back('{1,  0,  0, 320, 400, 0, 0});
        tbl.push_back('{1,  KW, 0, 320, 360, 0, 0});
        tbl.push_back('{1,  0,  0, 320, 360, 0, 0});
        tbl.push_back('{1,  KS, 0, 320, 360, 0, 0});
        tbl.push_back('{7,  0,  0, 320, 360, 0, 0});
        tbl.push_back('{1,  KS, 0, 320, 400, 0, 0});
        tbl.push_back('{9,  0,  0, 320, 400, 0, 0});
        for (int i = 0; i < 10; i++) begin
            xe = (320 - 40 * (i + 1) < 0) ? 0 : 320 - 40 * (i + 1);
            tbl.push_back('{1, KA, 0, xe, 400, 0, 0});
            tbl.push_back('{9, 0,  0, xe, 400, 0, 0});
        end
        tbl.push_back('{1,  KW, 1, 0,   400, 1, 0});
        tbl.push_back('{4,  0,  1, 0,   400, 0, 0});
        tbl.push_back('{25, 0,  0, 0,   400, 0, 0});
        tbl.push_back('{1,  0,  0, 320, 440, 0, 0});
        tbl.push_back('{1,  KW, 0, 320, 400, 0, 0});

        do_reset();
        foreach (tbl[j]) begin
            for (int n = 0; n < tbl[j].rep; n++) begin
                frame(tbl[j].key, tbl[j].haz, 0, 0);
                check($sformatf("tbl%0d_x", j), int'(Frog1_X), tbl[j].exp_x);
                check($sformatf("tbl%0d_y", j), int'(Frog1_Y), tbl[j].exp_y);
                check($sformatf("tbl%0d_dead", j), int'(dead_frog), int'(tbl[j].exp_dead));
                check($sformatf("tbl%0d_act", j), int'(active_frog), tbl[j].exp_act);
            end
        end

        // ---- log drift underflow and respawn timing ----
        do_reset();
        repeat (7) hop(KA);
        repeat (8) hop(KW);
        check("drift_start_x", int'(Frog1_X), 40);
        check("drift_start_y", int'(Frog1_Y), 120);
        repeat (12) frame(0, 0, DX_M3, 0);
        check("drift_x4", int'(Frog1_X), 4);
        frame(0, 0, DX_M3, 0);
        check("drift_x1", int'(Frog1_X), 1);
        check("drift_alive", int'(dead_frog), 0);
        frame(0, 0, DX_M3, 0);
        check("drift_dead_pulse", int'(dead_frog), 1);
        check("drift_hold_x", int'(Frog1_X), 1);
        frame(0, 0, DX_M3, 0);
        check("drift_pulse_end", int'(dead_frog), 0);
        repeat (28) frame(0, 0, 0, 0);
        check("drift_still_dead_y", int'(Frog1_Y), 120);
        frame(0, 0, 0, 0);
        check("respawn_x", int'(Frog1_X), 320);
        check("respawn_y", int'(Frog1_Y), 440);
        check("respawn_act", int'(active_frog), 0);

        // ---- homing all three frogs, including a used-slot death ----
        do_reset();
        hop(KA);
        repeat (9) hop(KW);
        frame(KW, 0, 0, 0);
        check("home1_y", int'(Frog1_Y), 40);
        check("home1_act", int'(active_frog), 0);
        frame(0, 0, 0, 0);
        check("spawn2_act", int'(active_frog), 1);
        check("spawn2_x", int'(Frog2_X), 320);
        check("spawn2_y", int'(Frog2_Y), 440);
        hop(KA);
        repeat (9) hop(KW);
        frame(KW, 0, 0, 0);
        check("used_slot_dead", int'(dead_frog), 1);
        check("used_slot_f1x", int'(Frog1_X), 280);
        check("used_slot_f1y", int'(Frog1_Y), 40);
        repeat (30) frame(0, 0, 0, 0);
        check("f2_respawn_y", int'(Frog2_Y), 440);
        repeat (5) hop(KA);
        repeat (10) hop(KW);
        check("home2_act", int'(active_frog), 2);
        check("home2_x", int'(Frog2_X), 120);
        repeat (4) hop(KD);
        repeat (10) hop(KW);
        check("all_home_act", int'(active_frog), 3);
        check("f3_x", int'(Frog3_X), 480);
        check("f3_y", int'(Frog3_Y), 40);
        frame(KA, 0, 0, 0); frame(KS, 1, 3, 0); frame(KD, 0, 0, 0); frame(KW, 0, 0, 0);
        check("done_hold_act", int'(active_frog), 3);
        check("done_hold_f3x", int'(Frog3_X), 480);
        check("done_no_dead", int'(dead_frog), 0);

        // ---- game_over freezes the death counter ----
        do_reset();
        hop(KW);
        frame(0, 1, 0, 0);
        check("go_dead_pulse", int'(dead_frog), 1);
        repeat (5) frame(0, 0, 0, 0);
        repeat (40) frame(0, 0, 0, 1);
        check("go_no_respawn", int'(Frog1_Y), 400);
        repeat (24) frame(0, 0, 0, 0);
        check("go_resume_hold", int'(Frog1_Y), 400);
        frame(0, 0, 0, 0);
        check("go_resume_respawn", int'(Frog1_Y), 440);

        // ---- reset in the middle of a death ----
        frame(0, 1, 0, 0);
        repeat (3) frame(0, 0, 0, 0);
        do_reset();

        // ---- randomized frames against the model ----
        for (int f = 0; f < 3000; f++) begin
            if (f % 600 == 599) do_reset();
            r = $urandom_range(0, 9);
            k = (r < 3) ? 0 : (r < 6) ? KW : (r == 6) ? KS : (r == 7) ? KA : (r == 8) ? KD : 'h2C;
            frame(k, ($urandom_range(0, 31) == 0), $urandom_range(0, 15), ($urandom_range(0, 63) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
